// File: rtl/ps2_receiver_pkg.sv
// Shared PS/2 keyboard definitions: frame geometry, default timing and FSM states.
package ps2_receiver_pkg;

    localparam int unsigned PS2_FRAME_BITS     = 11;
    localparam int unsigned PS2_DATA_BITS      = 8;
    localparam int unsigned PS2_FILTER_CYCLES  = 8;
    localparam int unsigned PS2_TIMEOUT_CYCLES = 9600;
    localparam int unsigned PS2_CNT_BITS       = 14;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } ps2_state_t;

    // Odd parity holds when data plus parity bit contain an odd number of ones.
    function automatic logic ps2_odd_parity_ok(input logic [PS2_DATA_BITS-1:0] d,
                                               input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchroniser plus deglitch filter for one raw PS/2 pin; idles high.
module ps2_line_filter
    import ps2_receiver_pkg::*;
#(
    parameter int unsigned FILTER_CYCLES = PS2_FILTER_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_filt
);

    localparam int unsigned CW = $clog2(FILTER_CYCLES + 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic [CW-1:0] r_cnt;

    // Two-flop synchroniser, then flip the level only after FILTER_CYCLES differing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_level <= 1'b1;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(FILTER_CYCLES - 1)) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_filt = r_level;

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 device-to-host receiver: deserialises 11-bit frames, checks start/odd
// parity/stop, and hands good bytes out on a valid/ready register.
module ps2_receiver
    import ps2_receiver_pkg::*;
#(
    parameter int unsigned FILTER_CYCLES  = PS2_FILTER_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES,
    parameter int unsigned CNT_BITS       = PS2_CNT_BITS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_error,
    output logic       overrun
);

    localparam int unsigned BW = $clog2(PS2_DATA_BITS);

    logic                     w_clk_filt;
    logic                     w_data_filt;
    logic                     r_clk_prev;
    logic                     w_fall;
    logic                     w_timeout;

    ps2_state_t               r_state;
    ps2_state_t               w_state_next;

    logic                     w_start;
    logic                     w_shift_en;
    logic                     w_parity_en;
    logic                     w_deliver;
    logic                     w_stop_err;
    logic                     w_frame_err;

    logic [BW-1:0]            r_bit_cnt;
    logic [PS2_DATA_BITS-1:0] r_shift;
    logic                     r_parity_ok;
    logic [CNT_BITS-1:0]      r_to_cnt;

    logic [7:0]               r_data;
    logic                     r_valid;
    logic                     r_frame_error;
    logic                     r_overrun;

    ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_clk_filter (
        .clk    (clk),
        .reset  (reset),
        .i_raw  (ps2_clk),
        .o_filt (w_clk_filt)
    );

    ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_data_filter (
        .clk    (clk),
        .reset  (reset),
        .i_raw  (ps2_data),
        .o_filt (w_data_filt)
    );

    // Remember the previous filtered clock level for falling-edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_clk_prev <= 1'b1;
        end else begin
            r_clk_prev <= w_clk_filt;
        end
    end

    assign w_fall    = r_clk_prev & ~w_clk_filt;
    assign w_timeout = (r_state != ST_IDLE) && (r_to_cnt == CNT_BITS'(TIMEOUT_CYCLES));

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: advances on fall strobes, timeout forces IDLE.
    always_comb begin
        w_state_next = r_state;
        if (w_timeout) begin
            w_state_next = ST_IDLE;
        end else if (w_fall) begin
            case (r_state)
                ST_IDLE:   if (!w_data_filt) w_state_next = ST_DATA;
                ST_DATA:   if (r_bit_cnt == BW'(PS2_DATA_BITS - 1)) w_state_next = ST_PARITY;
                ST_PARITY: w_state_next = ST_STOP;
                ST_STOP:   w_state_next = ST_IDLE;
                default:   w_state_next = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: per-state strobes for the datapath and result flags.
    always_comb begin
        w_start     = 1'b0;
        w_shift_en  = 1'b0;
        w_parity_en = 1'b0;
        w_deliver   = 1'b0;
        w_stop_err  = 1'b0;
        if (!w_timeout && w_fall) begin
            case (r_state)
                ST_IDLE:   w_start     = ~w_data_filt;
                ST_DATA:   w_shift_en  = 1'b1;
                ST_PARITY: w_parity_en = 1'b1;
                ST_STOP: begin
                    w_deliver  = w_data_filt & r_parity_ok;
                    w_stop_err = ~(w_data_filt & r_parity_ok);
                end
                default: ;
            endcase
        end
    end

    assign w_frame_err = w_stop_err | w_timeout;

    // Deserialiser: LSB-first shift, bit count and latched parity result.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_parity_ok <= 1'b0;
        end else begin
            if (w_start) begin
                r_bit_cnt <= '0;
            end
            if (w_shift_en) begin
                r_shift   <= {w_data_filt, r_shift[PS2_DATA_BITS-1:1]};
                r_bit_cnt <= r_bit_cnt + BW'(1);
            end
            if (w_parity_en) begin
                r_parity_ok <= ps2_odd_parity_ok(r_shift, w_data_filt);
            end
        end
    end

    // Inter-edge timeout: counts cycles between fall strobes while inside a frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_to_cnt <= '0;
        end else if (w_fall || (r_state == ST_IDLE) || w_timeout) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + CNT_BITS'(1);
        end
    end

    // Output register: loads when empty or being consumed, otherwise drops and flags overrun.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data        <= '0;
            r_valid       <= 1'b0;
            r_frame_error <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_frame_error <= w_frame_err;
            r_overrun     <= w_deliver & r_valid & ~ready;
            if (w_deliver && (!r_valid || ready)) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (r_valid && ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign data        = r_data;
    assign valid       = r_valid;
    assign frame_error = r_frame_error;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_ps2_receiver.sv
// Self-checking bench for ps2_receiver: directed vector table, corner-case
// sequences, and randomised frames against a frame-level reference model.
module tb_ps2_receiver;
    import ps2_receiver_pkg::*;

    localparam int unsigned H = 30;   // PS/2 half period in clk cycles

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       frame_error;
    logic       overrun;

    ps2_receiver #(
        .FILTER_CYCLES  (8),
        .TIMEOUT_CYCLES (9600),
        .CNT_BITS       (14)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .data        (data),
        .valid       (valid),
        .ready       (ready),
        .frame_error (frame_error),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned cyc = 0;
    int unsigned err_cnt = 0;
    int unsigned ovr_cnt = 0;
    int unsigned last_err_cyc = 0;
    int unsigned last_fall_cyc = 0;
    logic [7:0]  acc_q[$];
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [7:0]  prev_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pulse counters, accepted bytes, data stability while stalled.
    always @(negedge clk) begin
        if (frame_error) begin
            err_cnt++;
            last_err_cyc = cyc;
        end
        if (overrun) ovr_cnt++;
        if (valid && ready) acc_q.push_back(data);
        if (!reset && prev_valid && !prev_ready && valid) check("hold_data", data, prev_data);
        prev_valid = valid;
        prev_ready = ready;
        prev_data  = data;
    end

    task automatic wait_cyc(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] d, input logic par_flip,
                                               input logic stop_b);
        return {stop_b, (~^d) ^ par_flip, d, 1'b0};
    endfunction

    // Device-side serialiser: data set while clock high, host samples on fall.
    task automatic send_bits(input logic [10:0] fr, input int unsigned nb, input int gl);
        for (int i = 0; i < int'(nb); i++) begin
            ps2_data = fr[i];
            if (i == gl) begin
                wait_cyc(10);
                ps2_clk = 1'b0;
                wait_cyc(3);
                ps2_clk = 1'b1;
                wait_cyc(H - 13);
            end else begin
                wait_cyc(H);
            end
            ps2_clk = 1'b0;
            last_fall_cyc = cyc;
            wait_cyc(H);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        wait_cyc(H);
    endtask

    typedef struct {
        logic [7:0] d;
        logic       par_flip;
        logic       stop_b;
        logic       exp_good;
    } vec_t;

    vec_t        vt[6];
    int unsigned e0, o0, q0, dt;
    logic [7:0]  exp_q[$];
    logic        mpend;
    logic [7:0]  mdata;
    int unsigned exp_err, exp_ovr;

    initial begin
        reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        ready    = 1'b1;
        wait_cyc(5);
        check("rst_data", data, 8'h00);
        check("rst_valid", valid, 0);
        check("rst_ferr", frame_error, 0);
        check("rst_ovr", overrun, 0);
        reset = 1'b0;
        wait_cyc(30);
        check("idle_valid", valid, 0);
        check("idle_errs", err_cnt, 0);

        // Directed table, ready held high.
        vt[0] = '{8'h1C, 1'b0, 1'b1, 1'b1};
        vt[1] = '{8'h1C, 1'b1, 1'b1, 1'b0};
        vt[2] = '{8'h5A, 1'b0, 1'b1, 1'b1};
        vt[3] = '{8'h00, 1'b0, 1'b1, 1'b1};
        vt[4] = '{8'hFF, 1'b0, 1'b1, 1'b1};
        vt[5] = '{8'h29, 1'b0, 1'b0, 1'b0};
        for (int v = 0; v < 6; v++) begin
            e0 = err_cnt; o0 = ovr_cnt; q0 = acc_q.size();
            send_bits(make_frame(vt[v].d, vt[v].par_flip, vt[v].stop_b), 11, -1);
            wait_cyc(20);
            check($sformatf("vec%0d_err", v), err_cnt - e0, vt[v].exp_good ? 0 : 1);
            check($sformatf("vec%0d_ovr", v), ovr_cnt - o0, 0);
            check($sformatf("vec%0d_nbytes", v), acc_q.size() - q0, vt[v].exp_good ? 1 : 0);
            if (acc_q.size() > q0) check($sformatf("vec%0d_data", v), acc_q[q0], vt[v].d);
            check($sformatf("vec%0d_valid", v), valid, 0);
        end

        // Overrun: two good frames with ready low.
        ready = 1'b0;
        e0 = err_cnt; o0 = ovr_cnt;
        send_bits(make_frame(8'hF0, 1'b0, 1'b1), 11, -1);
        wait_cyc(20);
        check("ovr_valid1", valid, 1);
        check("ovr_data1", data, 8'hF0);
        check("ovr_cnt1", ovr_cnt - o0, 0);
        send_bits(make_frame(8'h1C, 1'b0, 1'b1), 11, -1);
        wait_cyc(20);
        check("ovr_cnt2", ovr_cnt - o0, 1);
        check("ovr_data2", data, 8'hF0);
        check("ovr_valid2", valid, 1);
        check("ovr_err", err_cnt - e0, 0);
        ready = 1'b1;
        wait_cyc(1);
        check("ovr_consumed", valid, 0);
        check("ovr_data_held", data, 8'hF0);

        // Timeout after four bits.
        e0 = err_cnt; q0 = acc_q.size();
        send_bits(make_frame(8'h33, 1'b0, 1'b1), 4, -1);
        wait_cyc(10000);
        check("to_err", err_cnt - e0, 1);
        dt = last_err_cyc - last_fall_cyc;
        check("to_time", (dt >= 9600 && dt <= 9660), 1);
        check("to_nbytes", acc_q.size() - q0, 0);
        send_bits(make_frame(8'h29, 1'b0, 1'b1), 11, -1);
        wait_cyc(20);
        check("to_next_n", acc_q.size() - q0, 1);
        if (acc_q.size() > q0) check("to_next_data", acc_q[q0], 8'h29);

        // Short clock glitches in IDLE and mid-frame.
        e0 = err_cnt; q0 = acc_q.size();
        for (int g = 0; g < 3; g++) begin
            ps2_clk = 1'b0;
            wait_cyc(3);
            ps2_clk = 1'b1;
            wait_cyc(20);
        end
        check("gl_idle_err", err_cnt - e0, 0);
        check("gl_idle_n", acc_q.size() - q0, 0);
        send_bits(make_frame(8'h1C, 1'b0, 1'b1), 11, 4);
        wait_cyc(20);
        check("gl_err", err_cnt - e0, 0);
        check("gl_n", acc_q.size() - q0, 1);
        if (acc_q.size() > q0) check("gl_data", acc_q[q0], 8'h1C);

        // Reset after the fifth data bit.
        e0 = err_cnt; o0 = ovr_cnt; q0 = acc_q.size();
        send_bits(make_frame(8'hA5, 1'b0, 1'b1), 6, -1);
        reset = 1'b1;
        wait_cyc(1);
        reset = 1'b0;
        check("mr_valid", valid, 0);
        check("mr_data", data, 8'h00);
        check("mr_ferr", frame_error, 0);
        check("mr_ovr", overrun, 0);
        wait_cyc(200);
        check("mr_err_cnt", err_cnt - e0, 0);
        send_bits(make_frame(8'h76, 1'b0, 1'b1), 11, -1);
        wait_cyc(20);
        check("mr_n", acc_q.size() - q0, 1);
        if (acc_q.size() > q0) check("mr_next_data", acc_q[q0], 8'h76);
        check("mr_ovr_cnt", ovr_cnt - o0, 0);

        // Randomised frames against a frame-level model of the byte register.
        acc_q.delete();
        e0 = err_cnt; o0 = ovr_cnt;
        mpend = 1'b0; mdata = '0; exp_err = 0; exp_ovr = 0;
        for (int f = 0; f < 24; f++) begin
            logic [7:0]  d;
            logic [10:0] fr;
            int unsigned kind;
            logic        r, good;
            d    = 8'($urandom);
            kind = $urandom_range(0, 3);
            r    = 1'($urandom_range(0, 1));
            fr   = make_frame(d, kind == 2, kind != 3);
            ready = r;
            wait_cyc(2);
            if (r && mpend) begin
                exp_q.push_back(mdata);
                mpend = 1'b0;
            end
            good = (fr[0] == 1'b0) && ($countones(fr[9:1]) % 2 == 1) && (fr[10] == 1'b1);
            if (!good) exp_err++;
            else if (r) exp_q.push_back(d);
            else if (mpend) exp_ovr++;
            else begin
                mpend = 1'b1;
                mdata = d;
            end
            send_bits(fr, 11, -1);
            wait_cyc(10);
        end
        ready = 1'b1;
        wait_cyc(3);
        if (mpend) exp_q.push_back(mdata);
        check("rnd_err", err_cnt - e0, exp_err);
        check("rnd_ovr", ovr_cnt - o0, exp_ovr);
        check("rnd_nbytes", acc_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < acc_q.size(); k++)
            check($sformatf("rnd_byte%0d", k), acc_q[k], exp_q[k]);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
